// File: rtl/abm_read_arbiter_pkg.sv
// ============================================================================
// Module : abm_read_arbiter_pkg
// Brief  : Shared types and helpers for the two-port ABM read arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package abm_read_arbiter_pkg;

  localparam int ABM_NUM_REQ = 2;

  typedef logic [7:0] abm_len_t;

  // Number of low-order byte-address bits that select a byte within one RAM word.
  function automatic int abm_word_offset(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/abm_read_arbiter_if.sv
// ============================================================================
// Module : abm_read_arbiter_if
// Brief  : One burst-read requester port: request and response handshakes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface abm_read_arbiter_if
  import abm_read_arbiter_pkg::*;
#(
  parameter int DW = 512,
  parameter int DD = 16384,
  parameter int BW = $clog2(DD * DW / 8)
) ();

  logic [BW-1:0] req_addr;
  abm_len_t      req_len;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_last;

  modport master (
    output req_addr, req_len, req_valid, rsp_ready,
    input  req_ready, rsp_data, rsp_valid, rsp_last
  );

  modport slave (
    input  req_addr, req_len, req_valid, rsp_ready,
    output req_ready, rsp_data, rsp_valid, rsp_last
  );

endinterface

`default_nettype wire

// File: rtl/abm_read_arbiter_rr_sel.sv
// ============================================================================
// Module : abm_rr_sel
// Brief  : Two-way round-robin pick; a lone requester always wins.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module abm_rr_sel
  import abm_read_arbiter_pkg::*;
(
  input  logic [ABM_NUM_REQ-1:0] valid,
  input  logic                   last_grant,
  output logic                   sel
);

  always_comb begin
    sel = ~last_grant;
    if (valid == 2'b01) begin
      sel = 1'b0;
    end else if (valid == 2'b10) begin
      sel = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/abm_read_arbiter.sv
// ============================================================================
// Module : abm_read_arbiter
// Brief  : Burst read arbiter sharing one address over two SDP RAM read ports.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module abm_read_arbiter
  import abm_read_arbiter_pkg::*;
#(
  parameter int DW = 512,
  parameter int DD = 16384,
  parameter int AW = $clog2(DD),
  parameter int BW = $clog2(DD * DW / 8)
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [AW-1:0]     ram_addr,
  input  logic [DW-1:0]     ram0_data,
  input  logic [DW-1:0]     ram1_data,
  abm_read_arbiter_if.slave r0,
  abm_read_arbiter_if.slave r1
);

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  localparam int c_BYTE_OFF = abm_word_offset(DW);

  state_t                 r_state, w_state_nxt;
  logic                   r_owner, w_owner_nxt;
  logic                   r_last_grant, w_last_grant_nxt;
  logic [AW-1:0]          r_ram_addr, w_ram_addr_nxt;
  abm_len_t               r_len, w_len_nxt;
  abm_len_t               r_beat, w_beat_nxt;
  logic [ABM_NUM_REQ-1:0] r_rsp_valid, w_rsp_valid_nxt;
  logic [DW-1:0]          r_rsp_data     [ABM_NUM_REQ];
  logic [DW-1:0]          w_rsp_data_nxt [ABM_NUM_REQ];

  logic [ABM_NUM_REQ-1:0] w_req_valid;
  logic [ABM_NUM_REQ-1:0] w_rsp_ready;
  logic                   w_sel;
  logic                   w_hs;
  logic                   w_last_beat;
  logic [BW-1:0]          w_req_addr;
  abm_len_t               w_req_len;

  assign w_req_valid = {r1.req_valid, r0.req_valid};
  assign w_rsp_ready = {r1.rsp_ready, r0.rsp_ready};

  abm_rr_sel u_rr_sel (
    .valid      (w_req_valid),
    .last_grant (r_last_grant),
    .sel        (w_sel)
  );

  assign w_req_addr  = w_sel ? r1.req_addr : r0.req_addr;
  assign w_req_len   = w_sel ? r1.req_len  : r0.req_len;
  assign w_hs        = (r_state == ST_ARB) && w_req_valid[w_sel];
  assign w_last_beat = (r_beat == r_len);

  // Ready is gated by resetn so it is low even before the first reset edge lands.
  assign r0.req_ready = resetn && (r_state == ST_ARB) && !w_sel;
  assign r1.req_ready = resetn && (r_state == ST_ARB) &&  w_sel;

  assign r0.rsp_valid = r_rsp_valid[0];
  assign r1.rsp_valid = r_rsp_valid[1];
  assign r0.rsp_data  = r_rsp_data[0];
  assign r1.rsp_data  = r_rsp_data[1];
  assign r0.rsp_last  = !r_owner && w_last_beat && r_rsp_valid[0];
  assign r1.rsp_last  =  r_owner && w_last_beat && r_rsp_valid[1];
  assign ram_addr     = r_ram_addr;

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_ram_addr_nxt   = r_ram_addr;
    w_len_nxt        = r_len;
    w_beat_nxt       = r_beat;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_data_nxt   = r_rsp_data;

    case (r_state)
      ST_ARB: begin
        if (w_hs) begin
          w_state_nxt    = ST_WAIT;
          w_owner_nxt    = w_sel;
          w_ram_addr_nxt = AW'(w_req_addr >> c_BYTE_OFF);
          w_len_nxt      = w_req_len;
          w_beat_nxt     = '0;
        end
      end
      ST_WAIT: begin
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        // RAM output now reflects ram_addr; prefetch the next word while this beat waits.
        w_state_nxt                  = ST_SEND;
        w_rsp_data_nxt[r_owner]      = ram0_data | ram1_data;
        w_rsp_valid_nxt[r_owner]     = 1'b1;
        w_ram_addr_nxt               = (r_ram_addr == AW'(DD - 1)) ? '0 : r_ram_addr + AW'(1);
      end
      ST_SEND: begin
        if (r_rsp_valid[r_owner] && w_rsp_ready[r_owner]) begin
          w_rsp_valid_nxt[r_owner] = 1'b0;
          if (w_last_beat) begin
            w_last_grant_nxt = r_owner;
            w_state_nxt      = ST_ARB;
          end else begin
            w_beat_nxt  = r_beat + abm_len_t'(1);
            w_state_nxt = ST_LOAD;
          end
        end
      end
      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_ARB;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_ram_addr   <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_rsp_valid  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_len        <= w_len_nxt;
      r_beat       <= w_beat_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
    end
  end

  // Beat data is only observed under rsp_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    r_rsp_data <= w_rsp_data_nxt;
  end

endmodule

`default_nettype wire

// File: tb/tb_abm_read_arbiter.sv
// ============================================================================
// Module : tb_abm_read_arbiter
// Brief  : Directed bench with a transaction-level reference model and scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_abm_read_arbiter;

  localparam int DW = 512;
  localparam int DD = 16384;
  localparam int AW = $clog2(DD);
  localparam int BW = $clog2(DD * DW / 8);
  localparam int WB = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int          owner;
    logic [31:0] lo;
    logic        last;
  } acc_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram0_data = '0;
  logic [DW-1:0] ram1_data = '0;

  abm_read_arbiter_if #(.DW(DW), .DD(DD)) r0i ();
  abm_read_arbiter_if #(.DW(DW), .DD(DD)) r1i ();

  abm_read_arbiter #(.DW(DW), .DD(DD)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ram_addr  (ram_addr),
    .ram0_data (ram0_data),
    .ram1_data (ram1_data),
    .r0        (r0i),
    .r1        (r1i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // RAM contents: low bits follow k<<1 / 1, upper bits carry extra marks.
  function automatic logic [DW-1:0] ram0_word(input int k);
    logic [DW-1:0] w;
    w             = '0;
    w[31:0]       = 32'(k << 1);
    w[DW-1 -: 32] = 32'hA5A5_0000 ^ 32'(k);
    return w;
  endfunction

  function automatic logic [DW-1:0] ram1_word(input int k);
    logic [DW-1:0] w;
    w              = '0;
    w[0]           = 1'b1;
    w[DW-33 -: 32] = 32'h0F0F_0000 | 32'(k);
    return w;
  endfunction

  always @(posedge clk) begin
    ram0_data <= ram0_word(int'(ram_addr));
    ram1_data <= ram1_word(int'(ram_addr));
  end

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit    m_busy       = 0;
  int    m_owner      = 0;
  int    m_last_grant = 1;
  int    m_cnt        = 0;
  int    m_hs_cnt     = 0;
  bit    m_first      = 0;
  int    lat_first    = -1;
  bit    prev_rst_low = 0;
  beat_t exp_q[$];
  int    grant_log[$];
  acc_t  acc_log[$];

  always @(negedge clk) begin
    logic [1:0]    v, rdy, rv, rr, lst;
    logic [DW-1:0] d [2];
    int            sel;
    int            word;
    int            len;
    v   = {r1i.req_valid, r0i.req_valid};
    rdy = {r1i.req_ready, r0i.req_ready};
    rv  = {r1i.rsp_valid, r0i.rsp_valid};
    rr  = {r1i.rsp_ready, r0i.rsp_ready};
    lst = {r1i.rsp_last,  r0i.rsp_last};
    d[0] = r0i.rsp_data;
    d[1] = r1i.rsp_data;

    if (!resetn) begin
      chk_bit("rst_req_ready0", rdy[0], 1'b0);
      chk_bit("rst_req_ready1", rdy[1], 1'b0);
      if (prev_rst_low) begin
        chk_bit("rst_rsp_valid0", rv[0], 1'b0);
        chk_bit("rst_rsp_valid1", rv[1], 1'b0);
      end
      prev_rst_low = 1;
      m_busy       = 0;
      m_last_grant = 1;
      exp_q.delete();
    end else begin
      prev_rst_low = 0;
      if (!m_busy) begin
        chk_bit("idle_rsp_valid0", rv[0], 1'b0);
        chk_bit("idle_rsp_valid1", rv[1], 1'b0);
        if (v != 2'b00) begin
          if (v == 2'b01)      sel = 0;
          else if (v == 2'b10) sel = 1;
          else                 sel = 1 - m_last_grant;
          chk_bit("arb_req_ready0", rdy[0], sel == 0);
          chk_bit("arb_req_ready1", rdy[1], sel == 1);
          if (v[sel]) begin
            word = int'(sel == 1 ? r1i.req_addr : r0i.req_addr) / WB;
            len  = int'(sel == 1 ? r1i.req_len  : r0i.req_len);
            for (int i = 0; i <= len; i++) begin
              beat_t b;
              b.data = ram0_word((word + i) % DD) | ram1_word((word + i) % DD);
              b.last = (i == len);
              exp_q.push_back(b);
            end
            m_owner  = sel;
            m_cnt    = 3;
            m_hs_cnt = 0;
            m_first  = 1;
            m_busy   = 1;
            grant_log.push_back(sel);
          end
        end
      end else begin
        chk_bit("busy_req_ready0", rdy[0], 1'b0);
        chk_bit("busy_req_ready1", rdy[1], 1'b0);
        chk_bit("nonowner_rsp_valid", rv[1 - m_owner], 1'b0);
        chk_bit("nonowner_rsp_last", lst[1 - m_owner], 1'b0);
        m_hs_cnt++;
        if (m_cnt > 0) m_cnt--;
        chk_bit("owner_rsp_valid", rv[m_owner], m_cnt == 0);
        if (rv[m_owner] && m_cnt == 0 && exp_q.size() > 0) begin
          if (m_first) begin
            lat_first = m_hs_cnt;
            m_first   = 0;
          end
          chk_val("rsp_data", d[m_owner], exp_q[0].data);
          chk_bit("rsp_last", lst[m_owner], exp_q[0].last);
          if (rr[m_owner]) begin
            acc_t a;
            a.owner = m_owner;
            a.lo    = d[m_owner][31:0];
            a.last  = lst[m_owner];
            acc_log.push_back(a);
            if (exp_q[0].last) begin
              m_busy       = 0;
              m_last_grant = m_owner;
            end else begin
              m_cnt = 2;
            end
            void'(exp_q.pop_front());
          end
        end else begin
          chk_bit("owner_rsp_last_low", lst[m_owner], 1'b0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_req(input int n, input int byte_addr, input int len);
    if (n == 0) begin
      r0i.req_addr  = BW'(byte_addr);
      r0i.req_len   = 8'(len);
      r0i.req_valid = 1'b1;
    end else begin
      r1i.req_addr  = BW'(byte_addr);
      r1i.req_len   = 8'(len);
      r1i.req_valid = 1'b1;
    end
  endtask

  task automatic wait_hs(input int n);
    bit got;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n == 0 ? (r0i.req_valid && r0i.req_ready) : (r1i.req_valid && r1i.req_ready)) begin
        got = 1;
        break;
      end
    end
    chk_bit("handshake_seen", got, 1'b1);
    @(posedge clk);
    #1;
    if (n == 0) r0i.req_valid = 1'b0;
    else        r1i.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit got;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (!m_busy) begin
        got = 1;
        break;
      end
    end
    chk_bit("burst_completed", got, 1'b1);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1 resetn = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_a;
    int base_g;
    bit got;
    resetn        = 1'b0;
    r0i.req_valid = 1'b0;
    r1i.req_valid = 1'b0;
    r0i.req_addr  = '0;
    r1i.req_addr  = '0;
    r0i.req_len   = '0;
    r1i.req_len   = '0;
    r0i.rsp_ready = 1'b1;
    r1i.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk_val("reset_ram_addr", DW'(ram_addr), '0);
    chk_bit("reset_rsp_valid0", r0i.rsp_valid, 1'b0);
    chk_bit("reset_rsp_valid1", r1i.rsp_valid, 1'b0);
    @(posedge clk);
    #1;

    // Single burst: byte 0x40 -> words 1..4.
    base_a = acc_log.size();
    drive_req(0, 32'h40, 3);
    wait_hs(0);
    wait_idle();
    chk_val("single_beats", DW'(acc_log.size() - base_a), DW'(4));
    if (acc_log.size() >= base_a + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk_val("single_data_lo", DW'(acc_log[base_a + i].lo), DW'(3 + 2 * i));
        chk_bit("single_last", acc_log[base_a + i].last, i == 3);
      end
    end
    chk_val("single_latency", DW'(lat_first), DW'(3));

    // Contention straight after reset, both held valid for four bursts.
    do_reset(2);
    base_g = grant_log.size();
    drive_req(0, 2 * WB, 0);
    drive_req(1, 5 * WB + 7, 1);
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (grant_log.size() >= base_g + 4) begin
        got = 1;
        break;
      end
    end
    #1;
    r0i.req_valid = 1'b0;
    r1i.req_valid = 1'b0;
    chk_bit("contention_four_grants", got, 1'b1);
    if (grant_log.size() >= base_g + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk_val("contention_grant_order", DW'(grant_log[base_g + i]), DW'(i % 2));
      end
    end
    wait_idle();

    // Backpressure on r1 beat 0 while r0 waits.
    base_a = acc_log.size();
    base_g = grant_log.size();
    drive_req(1, 7 * WB + 63, 1);
    wait_hs(1);
    r1i.rsp_ready = 1'b0;
    drive_req(0, 3 * WB, 0);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (r1i.rsp_valid) begin
        got = 1;
        break;
      end
    end
    chk_bit("bp_first_valid", got, 1'b1);
    repeat (5) @(posedge clk);
    #1 r1i.rsp_ready = 1'b1;
    wait_hs(0);
    wait_idle();
    chk_val("bp_beats", DW'(acc_log.size() - base_a), DW'(3));
    if (acc_log.size() >= base_a + 3) begin
      chk_val("bp_beat0_lo", DW'(acc_log[base_a].lo), DW'(15));
      chk_val("bp_beat1_lo", DW'(acc_log[base_a + 1].lo), DW'(17));
      chk_bit("bp_beat1_last", acc_log[base_a + 1].last, 1'b1);
      chk_val("bp_r0_after", DW'(acc_log[base_a + 2].owner), DW'(0));
    end
    if (grant_log.size() >= base_g + 2) begin
      chk_val("bp_grant0", DW'(grant_log[base_g]), DW'(1));
      chk_val("bp_grant1", DW'(grant_log[base_g + 1]), DW'(0));
    end

    // Address wrap from word DD-2.
    base_a = acc_log.size();
    drive_req(0, (DD - 2) * WB, 3);
    wait_hs(0);
    wait_idle();
    chk_val("wrap_beats", DW'(acc_log.size() - base_a), DW'(4));
    if (acc_log.size() >= base_a + 4) begin
      chk_val("wrap_w0", DW'(acc_log[base_a].lo),     DW'(32765));
      chk_val("wrap_w1", DW'(acc_log[base_a + 1].lo), DW'(32767));
      chk_val("wrap_w2", DW'(acc_log[base_a + 2].lo), DW'(1));
      chk_val("wrap_w3", DW'(acc_log[base_a + 3].lo), DW'(3));
    end

    // Reset while beat 2 of a burst is presented.
    base_a = acc_log.size();
    drive_req(0, 10 * WB, 3);
    wait_hs(0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (acc_log.size() >= base_a + 2) break;
    end
    #1 r0i.rsp_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r0i.rsp_valid) begin
        got = 1;
        break;
      end
    end
    chk_bit("midburst_beat2_valid", got, 1'b1);
    do_reset(2);
    r0i.rsp_ready = 1'b1;
    chk_val("midburst_beats_before", DW'(acc_log.size() - base_a), DW'(2));
    base_a = acc_log.size();
    base_g = grant_log.size();
    drive_req(1, 30 * WB, 0);
    drive_req(0, 20 * WB, 1);
    wait_hs(0);
    wait_hs(1);
    wait_idle();
    if (grant_log.size() >= base_g + 2) begin
      chk_val("post_reset_grant0", DW'(grant_log[base_g]), DW'(0));
      chk_val("post_reset_grant1", DW'(grant_log[base_g + 1]), DW'(1));
    end
    chk_val("post_reset_beats", DW'(acc_log.size() - base_a), DW'(3));
    if (acc_log.size() >= base_a + 3) begin
      chk_val("post_reset_b0", DW'(acc_log[base_a].lo),     DW'(41));
      chk_val("post_reset_b1", DW'(acc_log[base_a + 1].lo), DW'(43));
      chk_val("post_reset_b2", DW'(acc_log[base_a + 2].lo), DW'(61));
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/abm_read_arbiter.md
ABM_READ_ARBITER -- requirements
Module: abm_read_arbiter

Interface
REQ-001 Parameters SHALL be: DW, default 512, RAM word width in bits; DD, default 16384, RAM depth in words; AW = clog2(DD), word address width; BW = clog2(DD*DW/8), byte address width.
REQ-002 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 ram_addr  out  AW  shared read address to both SDP RAM read ports.
REQ-005 ram0_data, ram1_data  in  DW each  RAM read data; registered RAM output, valid on the second clock edge after ram_addr changes.
REQ-006 rN_req_addr  in  BW  byte address of burst start, for N = 0, 1.
REQ-007 rN_req_len  in  8  burst beats minus 1.
REQ-008 rN_req_valid / rN_req_ready  in / out  1  request handshake.
REQ-009 rN_rsp_data  out  DW  beat data, equal to ram0_data OR ram1_data.
REQ-010 rN_rsp_valid / rN_rsp_ready  out / in  1  response handshake.
REQ-011 rN_rsp_last  out  1  high on the final beat of the burst.

Function
REQ-012 The FSM SHALL have the states ARB, WAIT, LOAD and SEND.
REQ-013 In ARB, the selected requester SHALL be chosen combinationally:
- If only one requester is valid, that requester.
- If both are valid, the requester other than last_grant.
REQ-014 rN_req_ready SHALL equal (state==ARB AND selected==N); the other requester's ready SHALL be 0.
REQ-015 On a request handshake (ARB -> WAIT):
- owner <= N, ram_addr <= rN_req_addr >> clog2(DW/8), len <= rN_req_len, beat <= 0.
- Low-order byte-address bits SHALL be ignored.
REQ-016 WAIT SHALL last exactly 1 cycle, then go to LOAD.
REQ-017 LOAD SHALL last 1 cycle, then go to SEND:
- r[owner]_rsp_data <= ram0_data | ram1_data.
- r[owner]_rsp_valid <= 1.
- ram_addr <= ram_addr + 1, modulo DD (DD-1 wraps to 0).
REQ-018 In SEND, on r[owner]_rsp_valid AND rsp_ready:
- rsp_valid <= 0.
- If beat==len: last_grant <= owner, next state ARB.
- Otherwise: beat <= beat + 1, next state LOAD.
REQ-019 rN_rsp_last SHALL equal (owner==N AND beat==len AND rN_rsp_valid).
REQ-020 While valid is high and ready is low, rsp_data and rsp_last SHALL hold stable.
REQ-021 The non-owner's rsp_valid SHALL remain 0 for the entire burst.
REQ-022 Latency: the first rsp_valid SHALL rise 3 cycles after the request handshake edge.
REQ-023 With rsp_ready held high, beats SHALL arrive every 2 cycles.
REQ-024 len==0 SHALL produce a single beat with rsp_last high.
REQ-025 A request arriving during a burst SHALL wait; no preemption.
REQ-026 Requests SHALL be granted strictly at burst granularity.

Reset
REQ-027 On resetn==0, at any state including mid-burst:
- state <= ARB.
- Both rsp_valid <= 0.
- last_grant <= 1, so requester 0 wins first.
- ram_addr <= 0, beat <= 0, len <= 0, owner <= 0.
REQ-028 Both req_ready outputs SHALL be 0 while resetn==0.
REQ-029 An interrupted burst SHALL be discarded and not resumed.

Structure
REQ-030 FSM encodings SHALL be module-local localparams; no shared package is required.
REQ-031 The derived widths AW and BW SHALL be computed identically to abm_manager_if.
REQ-032 One sub-module, abm_rr_sel, SHALL implement the 2-way round-robin selection of REQ-013 (inputs: valid[1:0], last_grant; output: sel).

Verification
REQ-033 Single burst: r0 valid, addr 0x40, len 3, DW=512, ram0=k<<1, ram1=1 at word k, rsp_ready held 1.
- Expected: words 1..4 returned as (k<<1)|1.
- Expected: last on the 4th beat.
- Expected: first rsp_valid 3 cycles after the handshake.
REQ-034 Contention: both requesters valid in the same cycle after reset.
- Expected: r0 granted first, then r1.
- Expected: with both held valid, grants alternate 0,1,0,1.
REQ-035 Backpressure: r1 len 1, rsp_ready low for 5 cycles on beat 0.
- Expected: data stable throughout.
- Expected: no beat lost or duplicated.
- Expected: r0 stays ungranted until r1's last beat is accepted.
REQ-036 Wrap: r0 burst starting at word DD-2, len 3.
- Expected: words DD-2, DD-1, 0, 1 returned in order.
REQ-037 Reset mid-burst: assert resetn=0 during SEND of beat 2, then release.
- Expected: rsp_valid 0 the next cycle.
- Expected: after release, r0 wins arbitration.
- Expected: a fresh burst completes correctly.
